// File: rtl/regfile_sb_pkg.sv
// Shared encoding constants for the register file, so DEC, WB and LL units agree
// on the data width, index width, read-port limit and zero index.
package regfile_sb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MAX = 4;
  localparam int ZERO_IDX   = 0;

  // An index is writable unless it is the hardwired zero register.
  function automatic logic is_writable(input logic [31:0] idx, input logic zero_reg);
    return !(zero_reg && (idx == 32'(ZERO_IDX)));
  endfunction

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Busy bits for outstanding LL destinations, with a registered popcount.
// rd_busy is combinational and masks a same-cycle LL completion; no backpressure.
module regfile_sb_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     ll_valid,
  input  logic [ADDR_W-1:0]        ll_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             set_vld;
  logic             set_new;
  logic             clr_eff;

  assign set_vld = iss_valid && is_writable(32'(iss_addr), ZERO_REG != 0);
  assign set_new = set_vld && !busy_q[iss_addr];
  // A clear only counts when it actually retires a busy entry that is not re-issued now.
  assign clr_eff = ll_valid && busy_q[ll_addr] && !(set_vld && (iss_addr == ll_addr));

  always_comb begin
    busy_d = busy_q;
    if (clr_eff) busy_d[ll_addr] = 1'b0;
    if (set_vld) busy_d[iss_addr] = 1'b1;
    cnt_d = cnt_q + CNT_W'(set_new) - CNT_W'(clr_eff);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
    logic [ADDR_W-1:0] idx;
    assign idx        = rd_addr[i*ADDR_W +: ADDR_W];
    assign rd_busy[i] = busy_q[idx] && !(ll_valid && (ll_addr == idx));
  end

  assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Register file with WB and LL write ports, LL scoreboard and zero-latency reads;
// REGFILE_SB_BYPASS_EN forwards same-cycle write data to reads. No backpressure.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     wb_valid,
  input  logic [ADDR_W-1:0]        wb_addr,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     ll_valid,
  input  logic [ADDR_W-1:0]        ll_addr,
  input  logic [DATA_W-1:0]        ll_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic [ADDR_W:0]          busy_cnt,
  output logic                     wr_collide
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              wb_wr_vld;
  logic              ll_wr_req;
  logic              ll_wr_vld;
  logic              collide_d;

  assign wb_wr_vld = wb_valid && is_writable(32'(wb_addr), ZERO_REG != 0);
  assign ll_wr_req = ll_valid && is_writable(32'(ll_addr), ZERO_REG != 0);
  assign collide_d = wb_wr_vld && ll_wr_req && (wb_addr == ll_addr);
  // WB wins a same-index collision; the LL data is dropped.
  assign ll_wr_vld = ll_wr_req && !collide_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int n = 0; n < DEPTH; n++) mem_q[n] <= '0;
      wr_collide <= 1'b0;
    end else begin
      if (wb_wr_vld) mem_q[wb_addr] <= wb_data;
      if (ll_wr_vld) mem_q[ll_addr] <= ll_data;
      wr_collide <= collide_d;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] stored;
    logic [DATA_W-1:0] val;

    assign idx    = rd_addr[i*ADDR_W +: ADDR_W];
    assign stored = is_writable(32'(idx), ZERO_REG != 0) ? mem_q[idx] : '0;

`ifdef REGFILE_SB_BYPASS_EN
    always_comb begin
      val = stored;
      if (ll_wr_vld && (ll_addr == idx)) val = ll_data;
      if (wb_wr_vld && (wb_addr == idx)) val = wb_data;
    end
`else
    assign val = stored;
`endif

    assign rd_data[i*DATA_W +: DATA_W] = val;
  end

  regfile_sb_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .iss_valid(iss_valid),
    .iss_addr (iss_addr),
    .ll_valid (ll_valid),
    .ll_addr  (ll_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: reset, bypass, scoreboard, collisions, zero register.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic [4:0]  ll_addr;
  logic [31:0] ll_data;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic [5:0]  busy_cnt;
  logic        wr_collide;

  int errors = 0;
  int checks = 0;

  regfile_sb dut (
    .clk       (clk),
    .rstn      (rstn),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .ll_valid  (ll_valid),
    .ll_addr   (ll_addr),
    .ll_data   (ll_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .busy_cnt  (busy_cnt),
    .wr_collide(wr_collide)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 0; wb_addr = 0; wb_data = 0;
    ll_valid = 0; ll_addr = 0; ll_data = 0;
    iss_valid = 0; iss_addr = 0;
  endtask

  task automatic test_reset();
    rstn = 0;
    idle();
    rd_addr = 0;
    repeat (2) tick();
    for (int i = 0; i < 32; i++) begin
      rd_addr = {5'(31 - i), 5'(i)};
      #1;
      checks++;
      if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL reset_read idx=%0d: rd_data=%h rd_busy=%b, want 0/00", i, rd_data, rd_busy);
      end
    end
    checks++;
    if (busy_cnt !== 6'd0 || wr_collide !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy_cnt=%0d wr_collide=%b, want 0/0", busy_cnt, wr_collide);
    end
    rstn = 1;
    tick();
  endtask

  task automatic test_wb_bypass();
    logic [31:0] exp_same;
`ifdef REGFILE_SB_BYPASS_EN
    exp_same = 32'hDEADBEEF;
`else
    exp_same = 32'h0;
`endif
    wb_valid = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    rd_addr = {5'd0, 5'd5};
    #1;
    checks++;
    if (rd_data[31:0] !== exp_same) begin
      errors++;
      $display("FAIL wb_same_cycle: got %h want %h", rd_data[31:0], exp_same);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data[31:0] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wb_next_cycle: got %h want deadbeef", rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_addr = 7;
    tick();
    iss_addr = 9;
    tick();
    idle();
    rd_addr = {5'd9, 5'd7};
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL issue_two: busy_cnt=%0d rd_busy=%b, want 2/11", busy_cnt, rd_busy);
    end
    ll_valid = 1; ll_addr = 7; ll_data = 32'h1234;
    #1;
    checks++;
    if (rd_busy !== 2'b10 || busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL ll_clear_visible: rd_busy=%b busy_cnt=%0d, want 10/2", rd_busy, busy_cnt);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd1 || rd_busy !== 2'b10 || rd_data[31:0] !== 32'h1234) begin
      errors++;
      $display("FAIL ll_retire: busy_cnt=%0d rd_busy=%b x7=%h, want 1/10/00001234",
               busy_cnt, rd_busy, rd_data[31:0]);
    end
  endtask

  task automatic test_set_clear_same();
    iss_valid = 1; iss_addr = 3;
    tick();
    idle();
    rd_addr = {5'd9, 5'd3};
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL issue_x3: busy_cnt=%0d rd_busy=%b, want 2/11", busy_cnt, rd_busy);
    end
    iss_valid = 1; iss_addr = 3;
    ll_valid = 1; ll_addr = 3; ll_data = 32'h33;
    #1;
    checks++;
    if (rd_busy !== 2'b10) begin
      errors++;
      $display("FAIL set_clear_comb: rd_busy=%b, want 10", rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_busy !== 2'b11 || rd_data[31:0] !== 32'h33) begin
      errors++;
      $display("FAIL set_wins: busy_cnt=%0d rd_busy=%b x3=%h, want 2/11/00000033",
               busy_cnt, rd_busy, rd_data[31:0]);
    end
    iss_valid = 1; iss_addr = 9;
    tick();
    idle();
    #1;
    checks++;
    if (busy_cnt !== 6'd2 || rd_busy !== 2'b11) begin
      errors++;
      $display("FAIL reissue_busy: busy_cnt=%0d rd_busy=%b, want 2/11", busy_cnt, rd_busy);
    end
  endtask

  task automatic test_collide();
    logic [31:0] exp_same;
`ifdef REGFILE_SB_BYPASS_EN
    exp_same = 32'hAAAA;
`else
    exp_same = 32'h0;
`endif
    wb_valid = 1; wb_addr = 4; wb_data = 32'hAAAA;
    ll_valid = 1; ll_addr = 4; ll_data = 32'h5555;
    rd_addr = {5'd3, 5'd4};
    #1;
    checks++;
    if (wr_collide !== 1'b0 || rd_data[31:0] !== exp_same) begin
      errors++;
      $display("FAIL collide_same_cycle: wr_collide=%b x4=%h, want 0/%h", wr_collide, rd_data[31:0], exp_same);
    end
    tick();
    idle();
    #1;
    checks++;
    if (wr_collide !== 1'b1 || rd_data[31:0] !== 32'hAAAA || busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL collide_pulse: wr_collide=%b x4=%h busy_cnt=%0d, want 1/0000aaaa/2",
               wr_collide, rd_data[31:0], busy_cnt);
    end
    tick();
    checks++;
    if (wr_collide !== 1'b0) begin
      errors++;
      $display("FAIL collide_one_cycle: wr_collide=%b, want 0", wr_collide);
    end
  endtask

  task automatic test_zero_reg();
    wb_valid = 1; wb_addr = 0; wb_data = 32'hFFFFFFFF;
    ll_valid = 1; ll_addr = 0; ll_data = 32'hFFFFFFFF;
    iss_valid = 1; iss_addr = 0;
    rd_addr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
      errors++;
      $display("FAIL zero_same_cycle: rd_data=%h rd_busy=%b, want 0/00", rd_data, rd_busy);
    end
    tick();
    idle();
    #1;
    checks++;
    if (rd_data !== 64'd0 || rd_busy !== 2'b00 || wr_collide !== 1'b0 || busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL zero_after: rd_data=%h rd_busy=%b wr_collide=%b busy_cnt=%0d, want 0/00/0/2",
               rd_data, rd_busy, wr_collide, busy_cnt);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      wb_valid = 1; wb_addr = 5'(10 + k); wb_data = 32'h100 + k;
      ll_valid = 1; ll_addr = 5'(20 + k); ll_data = 32'h200 + k;
      tick();
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      rd_addr = {5'(20 + k), 5'(10 + k)};
      #1;
      checks++;
      if (rd_data[31:0] !== 32'h100 + k || rd_data[63:32] !== 32'h200 + k || rd_busy !== 2'b00) begin
        errors++;
        $display("FAIL b2b_read k=%0d: p0=%h p1=%h busy=%b, want %h/%h/00",
                 k, rd_data[31:0], rd_data[63:32], rd_busy, 32'h100 + k, 32'h200 + k);
      end
    end
    checks++;
    if (busy_cnt !== 6'd2) begin
      errors++;
      $display("FAIL ll_nonbusy_cnt: busy_cnt=%0d, want 2", busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    rd_addr = {5'd9, 5'd3};
    #2;
    rstn = 0;
    #1;
    checks++;
    if (busy_cnt !== 6'd0 || rd_busy !== 2'b00 || rd_data !== 64'd0 || wr_collide !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: busy_cnt=%0d rd_busy=%b rd_data=%h wr_collide=%b, want 0/00/0/0",
               busy_cnt, rd_busy, rd_data, wr_collide);
    end
    tick();
    rstn = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_scoreboard();
    test_set_clear_same();
    test_collide();
    test_zero_reg();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's general purpose register file.
- Configurable data width, register count and number of read ports.
- Two write ports:
  - WB port: single-cycle pipeline writeback.
  - LL port: long-latency units (load, mul/div).
- Built-in scoreboard of pending LL destinations, so the DEC stage can detect RAW hazards; same-cycle write-to-read bypass.
- Sits between DEC (reads, issue) and WB/LL completion (writes).

Parameters:
- DATA_W, 32, register data width.
- ADDR_W, 5, index width; depth = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 hardwired to zero, never written, never busy.

Ports:
- clk  input  1  core clock.
- rstn  input  1  asynchronous active-low reset.
- wb_valid  input  1  WB-port write enable.
- wb_addr  input  ADDR_W  WB destination index.
- wb_data  input  DATA_W  WB write data.
- ll_valid  input  1  LL-port write enable; also clears the scoreboard entry.
- ll_addr  input  ADDR_W  LL destination index.
- ll_data  input  DATA_W  LL write data.
- iss_valid  input  1  an LL instruction issues; marks its destination busy.
- iss_addr  input  ADDR_W  issued LL destination.
- rd_addr  input  NUM_RD*ADDR_W  packed read indices; port i uses bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  packed read data (combinational).
- rd_busy  output  NUM_RD  per-port: the indexed register has an outstanding LL write.
- busy_cnt  output  ADDR_W+1  registered count of busy entries.
- wr_collide  output  1  registered one-cycle pulse: WB and LL wrote the same index in the previous cycle.

Behaviour:
- Reset (rstn low, asynchronous):
  - all registers = 0; all busy bits = 0.
  - busy_cnt = 0; wr_collide = 0.
  - rd_data and rd_busy follow from the cleared state.
- Writes: at posedge clk, the register at wb_addr takes wb_data if wb_valid; the register at ll_addr takes ll_data if ll_valid.
- Same-index writes (both valid, equal address, index writable):
  - WB wins; LL data is dropped.
  - The LL busy-clear still takes effect.
  - wr_collide = 1 for the next cycle only.
- ZERO_REG=1:
  - writes to index 0 are ignored and never raise wr_collide.
  - iss_valid to index 0 never sets busy.
  - reads of index 0 return 0 and rd_busy = 0.
- Reads: zero-latency combinational; the value reflects bypass (see Optional Feature).
- Scoreboard busy[n], updated at posedge:
  - iss_valid with iss_addr==n sets busy[n].
  - ll_valid with ll_addr==n clears busy[n].
  - Set and clear of the same n in one cycle: set wins (new issue overrides the retiring one).
  - iss_valid to an already-busy entry: stays busy, no error.
  - ll_valid to a non-busy entry: write still occurs, busy stays 0.
- rd_busy[i] = busy[rd_addr_i] && !(ll_valid && ll_addr==rd_addr_i). The same-cycle clear is visible, so DEC never stalls on a completing write.
- busy_cnt:
  - Registered, and always equals popcount(busy) of the current state.
  - Updated by +1 for a set, -1 for a clear, net 0 when both apply; range 0..2**ADDR_W (ZERO_REG excludes index 0).
  - Must not wrap.
- No state other than registers, busy bits, busy_cnt and wr_collide.

Optional Feature:
- Macro REGFILE_SB_BYPASS_EN.
- Defined: rd_data for port i returns
  - wb_data if wb_valid and wb_addr matches (writable index);
  - else ll_data if ll_valid and ll_addr matches;
  - else the stored value.
- Undefined: rd_data always returns the stored value; a write is visible from the cycle after the write edge.
- Scoreboard behaviour is identical in both builds.

Decomposition:
- Shared package: data width, index width, read-port limit and zero-index constants, so DEC, WB and LL units agree on the encoding.
- One natural sub-module, regfile_sb_scoreboard:
  - holds the busy bits and busy_cnt;
  - produces the per-port rd_busy;
  - the top level holds the storage array, write arbitration, bypass mux and wr_collide.

Test Plan:
- Reset then read indices 0..31 -> all rd_data = 0, rd_busy = 0, busy_cnt = 0.
- wb write x5 = 0xDEADBEEF, read x5 on port 0 in the same cycle:
  - with REGFILE_SB_BYPASS_EN: 0xDEADBEEF;
  - without: 0, then 0xDEADBEEF next cycle.
- Issue x7, x9 -> busy_cnt = 2, rd_busy set on x7; ll write x7 = 0x1234 -> rd_busy x7 = 0 that cycle, busy_cnt = 1 next, x7 reads 0x1234.
- Same cycle iss_valid x3 and ll_valid x3 (x3 busy) -> x3 remains busy, busy_cnt unchanged.
- wb x4 = 0xAAAA and ll x4 = 0x5555 together -> x4 = 0xAAAA, wr_collide pulses high for exactly one cycle.
- Writes and issue to x0 with value 0xFFFFFFFF -> x0 reads 0, never busy, wr_collide stays 0. Assert rstn mid-operation with busy entries -> busy_cnt = 0 immediately.
